// File: rtl/control_unit_if.sv
// Control-unit <-> data-path bundle: IR/flag inputs to the sequencer, strobes and selects back out.
interface control_unit_if;
  logic [7:0] IR_Value;
  logic       ac_zero;
  logic       IR_Load;
  logic       DR_Load;
  logic       PC_Load;
  logic       AR_Load;
  logic       AC_Load;
  logic       DR_Inc;
  logic       AC_Inc;
  logic       PC_Inc;
  logic [1:0] bus_sel;
  logic [2:0] alu_sel;
  logic       mem_we;
  logic       halted;
  logic       illegal_op;
  logic [3:0] state_o;

  modport master (
    input  IR_Value, ac_zero,
    output IR_Load, DR_Load, PC_Load, AR_Load, AC_Load,
           DR_Inc, AC_Inc, PC_Inc, bus_sel, alu_sel,
           mem_we, halted, illegal_op, state_o
  );

  modport slave (
    output IR_Value, ac_zero,
    input  IR_Load, DR_Load, PC_Load, AR_Load, AC_Load,
           DR_Inc, AC_Inc, PC_Inc, bus_sel, alu_sel,
           mem_we, halted, illegal_op, state_o
  );
endinterface

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU; Moore outputs, registered.
// Optional feature macro CU_JMPZ_EN: enables JMPZ (opcode 0x5) and the JZSKIP state.
module control_unit #(
  parameter logic [3:0] HALT_OPC = 4'hF
) (
  input logic            clk,
  input logic            rst,
  control_unit_if.master cu
);
  localparam int unsigned STATE_W   = 4;
  localparam int unsigned BUS_SEL_W = 2;
  localparam int unsigned ALU_SEL_W = 3;
  localparam int unsigned OPC_W     = 4;

  localparam logic [BUS_SEL_W-1:0] BUS_DR  = BUS_SEL_W'(0);
  localparam logic [BUS_SEL_W-1:0] BUS_AC  = BUS_SEL_W'(1);
  localparam logic [BUS_SEL_W-1:0] BUS_MEM = BUS_SEL_W'(2);
  localparam logic [BUS_SEL_W-1:0] BUS_PC  = BUS_SEL_W'(3);

  localparam logic [OPC_W-1:0] OPC_NOP  = OPC_W'(4'h0);
  localparam logic [OPC_W-1:0] OPC_ADD  = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OPC_STAC = OPC_W'(4'h2);
  localparam logic [OPC_W-1:0] OPC_INAC = OPC_W'(4'h3);
  localparam logic [OPC_W-1:0] OPC_JUMP = OPC_W'(4'h4);
`ifdef CU_JMPZ_EN
  localparam logic [OPC_W-1:0] OPC_JMPZ = OPC_W'(4'h5);
`endif

  typedef enum logic [STATE_W-1:0] {
    S_FETCH1 = 4'd0,
    S_FETCH2 = 4'd1,
    S_DECODE = 4'd2,
    S_ADD1   = 4'd3,
    S_ADD2   = 4'd4,
    S_ADD3   = 4'd5,
    S_ADD4   = 4'd6,
    S_ST1    = 4'd7,
    S_ST2    = 4'd8,
    S_ST3    = 4'd9,
    S_INC1   = 4'd10,
    S_JMP1   = 4'd11,
    S_JMP2   = 4'd12,
`ifdef CU_JMPZ_EN
    S_JZSKIP = 4'd13,
`endif
    S_HALT   = 4'd14
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_run;
  logic [OPC_W-1:0]       w_opc;
  logic [3:0]             w_unused_ir_low;
  logic                   w_illegal;

  logic                   w_ir_load, w_dr_load, w_pc_load, w_ar_load, w_ac_load;
  logic                   w_ac_inc, w_pc_inc, w_mem_we, w_halted;
  logic [BUS_SEL_W-1:0]   w_bus_sel;

  logic                   r_ir_load, r_dr_load, r_pc_load, r_ar_load, r_ac_load;
  logic                   r_ac_inc, r_pc_inc, r_mem_we, r_halted, r_illegal_op;
  logic [BUS_SEL_W-1:0]   r_bus_sel;

  assign w_opc           = cu.IR_Value[7:4];
  assign w_unused_ir_low = cu.IR_Value[3:0];

  // Next state, then the output set of that next state so outputs line up with r_state.
  always_comb begin
    w_next_state = r_state;
    w_illegal    = 1'b0;
    w_ir_load    = 1'b0;
    w_dr_load    = 1'b0;
    w_pc_load    = 1'b0;
    w_ar_load    = 1'b0;
    w_ac_load    = 1'b0;
    w_ac_inc     = 1'b0;
    w_pc_inc     = 1'b0;
    w_mem_we     = 1'b0;
    w_halted     = 1'b0;
    w_bus_sel    = BUS_DR;

    if (!r_run) begin
      w_next_state = S_FETCH1;
    end else begin
      case (r_state)
        S_FETCH1: w_next_state = S_FETCH2;
        S_FETCH2: w_next_state = S_DECODE;
        S_DECODE: begin
          if (w_opc == HALT_OPC) begin
            w_next_state = S_HALT;
          end else begin
            case (w_opc)
              OPC_NOP:  w_next_state = S_FETCH1;
              OPC_ADD:  w_next_state = S_ADD1;
              OPC_STAC: w_next_state = S_ST1;
              OPC_INAC: w_next_state = S_INC1;
              OPC_JUMP: w_next_state = S_JMP1;
`ifdef CU_JMPZ_EN
              OPC_JMPZ: w_next_state = cu.ac_zero ? S_JMP1 : S_JZSKIP;
`endif
              default: begin
                w_next_state = S_FETCH1;
                w_illegal    = 1'b1;
              end
            endcase
          end
        end
        S_ADD1:   w_next_state = S_ADD2;
        S_ADD2:   w_next_state = S_ADD3;
        S_ADD3:   w_next_state = S_ADD4;
        S_ST1:    w_next_state = S_ST2;
        S_ST2:    w_next_state = S_ST3;
        S_JMP1:   w_next_state = S_JMP2;
        S_HALT:   w_next_state = S_HALT;
        default:  w_next_state = S_FETCH1;
      endcase
    end

    case (w_next_state)
      S_FETCH1, S_ADD1, S_ST1, S_JMP1: begin
        w_bus_sel = BUS_PC;
        w_ar_load = 1'b1;
      end
      S_FETCH2: begin
        w_bus_sel = BUS_MEM;
        w_ir_load = 1'b1;
        w_pc_inc  = 1'b1;
      end
      S_ADD2, S_ST2: begin
        w_bus_sel = BUS_MEM;
        w_ar_load = 1'b1;
        w_pc_inc  = 1'b1;
      end
      S_ADD3: begin
        w_bus_sel = BUS_MEM;
        w_dr_load = 1'b1;
      end
      S_ADD4:   w_ac_load = 1'b1;
      S_ST3: begin
        w_bus_sel = BUS_AC;
        w_mem_we  = 1'b1;
      end
      S_INC1:   w_ac_inc = 1'b1;
      S_JMP2: begin
        w_bus_sel = BUS_MEM;
        w_pc_load = 1'b1;
      end
`ifdef CU_JMPZ_EN
      S_JZSKIP: w_pc_inc = 1'b1;
`endif
      S_HALT:   w_halted = 1'b1;
      default:  ;
    endcase
  end

  // r_run holds the sequencer in FETCH1 for the first edge after reset so its strobes appear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_FETCH1;
      r_run        <= 1'b0;
      r_ir_load    <= 1'b0;
      r_dr_load    <= 1'b0;
      r_pc_load    <= 1'b0;
      r_ar_load    <= 1'b0;
      r_ac_load    <= 1'b0;
      r_ac_inc     <= 1'b0;
      r_pc_inc     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_halted     <= 1'b0;
      r_illegal_op <= 1'b0;
      r_bus_sel    <= BUS_DR;
    end else begin
      r_state      <= w_next_state;
      r_run        <= 1'b1;
      r_ir_load    <= w_ir_load;
      r_dr_load    <= w_dr_load;
      r_pc_load    <= w_pc_load;
      r_ar_load    <= w_ar_load;
      r_ac_load    <= w_ac_load;
      r_ac_inc     <= w_ac_inc;
      r_pc_inc     <= w_pc_inc;
      r_mem_we     <= w_mem_we;
      r_halted     <= w_halted;
      r_illegal_op <= w_illegal;
      r_bus_sel    <= w_bus_sel;
    end
  end

  assign cu.IR_Load    = r_ir_load;
  assign cu.DR_Load    = r_dr_load;
  assign cu.PC_Load    = r_pc_load;
  assign cu.AR_Load    = r_ar_load;
  assign cu.AC_Load    = r_ac_load;
  assign cu.DR_Inc     = 1'b0;
  assign cu.AC_Inc     = r_ac_inc;
  assign cu.PC_Inc     = r_pc_inc;
  assign cu.bus_sel    = r_bus_sel;
  assign cu.alu_sel    = ALU_SEL_W'(0);
  assign cu.mem_we     = r_mem_we;
  assign cu.halted     = r_halted;
  assign cu.illegal_op = r_illegal_op;
  assign cu.state_o    = r_state;
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: behavioural data path + memory, per-cycle scoreboard of state/outputs.
module tb_control_unit;
  localparam logic [3:0] S_F1 = 4'd0, S_F2 = 4'd1, S_DEC = 4'd2, S_ADD1 = 4'd3,
                         S_ADD2 = 4'd4, S_ADD3 = 4'd5, S_ADD4 = 4'd6, S_ST1 = 4'd7,
                         S_ST2 = 4'd8, S_ST3 = 4'd9, S_INC1 = 4'd10, S_JMP1 = 4'd11,
                         S_JMP2 = 4'd12, S_JZSKIP = 4'd13, S_HALT = 4'd14;
`ifdef CU_JMPZ_EN
  localparam bit JMPZ_EN = 1'b1;
`else
  localparam bit JMPZ_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] bs;
    logic       ill;
    logic       hlt;
    logic       we;
  } exp_t;

  logic clk;
  logic rst;
  control_unit_if cu_if ();

  control_unit #(.HALT_OPC(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .cu  (cu_if)
  );

  logic [7:0] pc, ar, ir, dr, ac, bus;
  logic [7:0] mem [256];
  logic       pl_we;
  logic [7:0] pl_addr, pl_data;

  exp_t q_exp[$];
  logic pend_ill;
  int   total, bad, we_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cu_if.IR_Value = ir;
  assign cu_if.ac_zero  = (ac == 8'h00);

  always_comb begin
    case (cu_if.bus_sel)
      2'b00:   bus = dr;
      2'b01:   bus = ac;
      2'b10:   bus = mem[ar];
      default: bus = pc;
    endcase
  end

  // Reference data path driven by the strobes.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= 8'h10; ar <= 8'h00; ir <= 8'h00; dr <= 8'h00; ac <= 8'h00;
    end else begin
      if (cu_if.AR_Load) ar <= bus;
      if (cu_if.IR_Load) ir <= bus;
      if (cu_if.DR_Load) dr <= bus;
      else if (cu_if.DR_Inc) dr <= dr + 8'd1;
      if (cu_if.PC_Load) pc <= bus;
      else if (cu_if.PC_Inc) pc <= pc + 8'd1;
      if (cu_if.AC_Load) ac <= ac + dr;
      else if (cu_if.AC_Inc) ac <= ac + 8'd1;
    end
  end

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (cu_if.mem_we) mem[ar] <= bus;
  end

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic push_state(input logic [3:0] st);
    exp_t e;
    e.st  = st;
    e.we  = (st == S_ST3);
    e.hlt = (st == S_HALT);
    e.ill = (st == S_F1) ? pend_ill : 1'b0;
    if (st == S_F1) pend_ill = 1'b0;
    case (st)
      S_F1, S_ADD1, S_ST1, S_JMP1:   e.bs = 2'b11;
      S_F2, S_ADD2, S_ADD3, S_ST2, S_JMP2: e.bs = 2'b10;
      S_ST3:                         e.bs = 2'b01;
      default:                       e.bs = 2'b00;
    endcase
    q_exp.push_back(e);
  endtask

  task automatic push_instr(input logic [3:0] opc, input logic acz);
    push_state(S_F1); push_state(S_F2); push_state(S_DEC);
    case (opc)
      4'h0: ;
      4'h1: begin push_state(S_ADD1); push_state(S_ADD2); push_state(S_ADD3); push_state(S_ADD4); end
      4'h2: begin push_state(S_ST1); push_state(S_ST2); push_state(S_ST3); end
      4'h3: push_state(S_INC1);
      4'h4: begin push_state(S_JMP1); push_state(S_JMP2); end
      4'h5: begin
        if (!JMPZ_EN) pend_ill = 1'b1;
        else if (acz) begin push_state(S_JMP1); push_state(S_JMP2); end
        else push_state(S_JZSKIP);
      end
      4'hF: begin push_state(S_HALT); push_state(S_HALT); push_state(S_HALT); end
      default: pend_ill = 1'b1;
    endcase
  endtask

  // Scoreboard consumer: one comparison per cycle, bounded by the queue length.
  task automatic drain(input string name);
    exp_t e, got;
    int cyc;
    cyc = 0;
    while (q_exp.size() > 0) begin
      @(posedge clk); #1;
      e   = q_exp.pop_front();
      got = {cu_if.state_o, cu_if.bus_sel, cu_if.illegal_op, cu_if.halted, cu_if.mem_we};
      if (cu_if.mem_we) we_cnt++;
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s cyc%0d: got st=%0d bs=%b ill=%b hlt=%b we=%b, want st=%0d bs=%b ill=%b hlt=%b we=%b",
                 name, cyc, got.st, got.bs, got.ill, got.hlt, got.we, e.st, e.bs, e.ill, e.hlt, e.we);
      end
      cyc++;
    end
  endtask

  task automatic start_prog();
    rst = 1'b0; pend_ill = 1'b0; we_cnt = 0;
    q_exp.delete();
    #1;
  endtask

  task automatic test_reset();
    start_prog();
    @(posedge clk); #1;
    total++;
    if ({cu_if.state_o, cu_if.bus_sel, cu_if.alu_sel, cu_if.IR_Load, cu_if.DR_Load, cu_if.PC_Load,
         cu_if.AR_Load, cu_if.AC_Load, cu_if.DR_Inc, cu_if.AC_Inc, cu_if.PC_Inc, cu_if.mem_we,
         cu_if.halted, cu_if.illegal_op} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs: state=%0d bus_sel=%b mem_we=%b halted=%b, want all zero",
               cu_if.state_o, cu_if.bus_sel, cu_if.mem_we, cu_if.halted);
    end
  endtask

  task automatic test_nop();
    start_prog();
    load(8'h10, 8'h00); load(8'h11, 8'h00); load(8'h12, 8'h00); load(8'h13, 8'hF0);
    release_rst();
    push_instr(4'h0, 1'b0); push_instr(4'h0, 1'b0); push_instr(4'h0, 1'b0); push_instr(4'hF, 1'b0);
    drain("nop");
    total++;
    if (pc !== 8'h14 || we_cnt != 0) begin
      bad++; $display("FAIL nop_end: pc=%h we_cnt=%0d, want pc=14 we_cnt=0", pc, we_cnt);
    end
  endtask

  task automatic test_inac_halt();
    start_prog();
    load(8'h10, 8'h30); load(8'h11, 8'h30); load(8'h12, 8'hF0);
    release_rst();
    push_instr(4'h3, 1'b0); push_instr(4'h3, 1'b0); push_instr(4'hF, 1'b0);
    drain("inac_halt");
    total++;
    if (ac !== 8'h02 || pc !== 8'h13 || cu_if.halted !== 1'b1) begin
      bad++; $display("FAIL inac_halt_end: ac=%h pc=%h halted=%b, want ac=02 pc=13 halted=1", ac, pc, cu_if.halted);
    end
  endtask

  task automatic test_add_stac();
    start_prog();
    load(8'h80, 8'h05); load(8'h81, 8'hAA);
    load(8'h10, 8'h10); load(8'h11, 8'h80); load(8'h12, 8'h20); load(8'h13, 8'h81); load(8'h14, 8'hF0);
    release_rst();
    push_instr(4'h1, 1'b0);
    drain("add");
    @(posedge clk); #1;
    total++;
    if (ac !== 8'h05) begin bad++; $display("FAIL add_ac: ac=%h, want 05", ac); end
    push_state(S_F2); push_state(S_DEC); push_state(S_ST1); push_state(S_ST2); push_state(S_ST3);
    push_instr(4'hF, 1'b0);
    drain("stac");
    total++;
    if (mem[8'h81] !== 8'h05 || we_cnt != 1 || pc !== 8'h15) begin
      bad++; $display("FAIL stac_end: mem81=%h we_cnt=%0d pc=%h, want 05 1 15", mem[8'h81], we_cnt, pc);
    end
  endtask

  task automatic test_jmpz();
    // AC = 0
    start_prog();
    load(8'h10, 8'h50); load(8'h11, (JMPZ_EN ? 8'h40 : 8'h00)); load(8'h12, 8'hF0); load(8'h40, 8'hF0);
    release_rst();
    push_instr(4'h5, 1'b1);
    if (!JMPZ_EN) push_instr(4'h0, 1'b0);
    push_instr(4'hF, 1'b0);
    drain("jmpz_acz");
    total++;
    if (pc !== (JMPZ_EN ? 8'h41 : 8'h13)) begin
      bad++; $display("FAIL jmpz_acz_pc: pc=%h, want %h", pc, (JMPZ_EN ? 8'h41 : 8'h13));
    end
    // AC = 1 via INAC
    start_prog();
    load(8'h10, 8'h30); load(8'h11, 8'h50); load(8'h12, (JMPZ_EN ? 8'h40 : 8'h00)); load(8'h13, 8'hF0);
    release_rst();
    push_instr(4'h3, 1'b0); push_instr(4'h5, 1'b0);
    if (!JMPZ_EN) push_instr(4'h0, 1'b0);
    push_instr(4'hF, 1'b0);
    drain("jmpz_acnz");
    total++;
    if (pc !== 8'h14 || ac !== 8'h01) begin
      bad++; $display("FAIL jmpz_acnz_end: pc=%h ac=%h, want 14 01", pc, ac);
    end
  endtask

  task automatic test_illegal();
    start_prog();
    load(8'h10, 8'hA7); load(8'h11, 8'h00); load(8'h12, 8'hF0);
    release_rst();
    push_instr(4'hA, 1'b0); push_instr(4'h0, 1'b0); push_instr(4'hF, 1'b0);
    drain("illegal");
    total++;
    if (pc !== 8'h13) begin bad++; $display("FAIL illegal_pc: pc=%h, want 13", pc); end
  endtask

  task automatic test_reset_mid();
    start_prog();
    load(8'h81, 8'h55);
    load(8'h10, 8'h20); load(8'h11, 8'h81); load(8'h12, 8'hF0);
    release_rst();
    push_state(S_F1); push_state(S_F2); push_state(S_DEC); push_state(S_ST1); push_state(S_ST2);
    drain("reset_mid_pre");
    rst = 1'b0;
    #1;
    total++;
    if ({cu_if.state_o, cu_if.bus_sel, cu_if.AR_Load, cu_if.PC_Inc, cu_if.mem_we} !== 9'h0) begin
      bad++; $display("FAIL reset_mid_async: state=%0d bus_sel=%b ar_ld=%b pc_inc=%b we=%b, want zero",
                      cu_if.state_o, cu_if.bus_sel, cu_if.AR_Load, cu_if.PC_Inc, cu_if.mem_we);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (cu_if.mem_we) we_cnt++;
    end
    total++;
    if (we_cnt != 0 || mem[8'h81] !== 8'h55) begin
      bad++; $display("FAIL reset_mid_nostore: we_cnt=%0d mem81=%h, want 0 55", we_cnt, mem[8'h81]);
    end
    release_rst();
    push_instr(4'h2, 1'b0); push_instr(4'hF, 1'b0);
    drain("reset_mid_resume");
    total++;
    if (mem[8'h81] !== 8'h00 || pc !== 8'h13 || we_cnt != 1) begin
      bad++; $display("FAIL reset_mid_end: mem81=%h pc=%h we_cnt=%0d, want 00 13 1", mem[8'h81], pc, we_cnt);
    end
  endtask

  initial begin
    total = 0; bad = 0; we_cnt = 0; pend_ill = 1'b0;
    rst = 1'b0; pl_we = 1'b0; pl_addr = 8'h00; pl_data = 8'h00;
    test_reset();
    test_nop();
    test_inac_halt();
    test_add_stac();
    test_jmpz();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_unit.md
# control_unit

Instruction-sequencing FSM for the 8-bit accumulator CPU. It sits directly upstream of the data path and drives every register load/increment strobe and bus-select code. It consumes the instruction register value and an accumulator-zero flag that come back from the data path. It implements fetch, decode and execute for a small one- and two-byte instruction set over a shared 8-bit bus and an asynchronous-read memory.

## Interface
Parameters:
- `HALT_OPC`, default 4'hF: opcode that stops the sequencer.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `IR_Value`  in  8  instruction register from the data path; opcode = `IR_Value[7:4]`, `IR_Value[3:0]` ignored.
- `ac_zero`  in  1  high when AC == 8'h00.
- `IR_Load`, `DR_Load`, `PC_Load`, `AR_Load`, `AC_Load`  out  1 each  data-path load strobes. `AC_Load` performs AC <= AC + DR.
- `DR_Inc`, `AC_Inc`, `PC_Inc`  out  1 each  data-path increment strobes.
- `bus_sel`  out  2  bus source: 00 DR, 01 AC, 10 memory read data, 11 PC.
- `alu_sel`  out  3  held at 3'b000.
- `mem_we`  out  1  memory write strobe; write data is the bus, address is AR.
- `halted`  out  1  high while in HALT.
- `illegal_op`  out  1  one-cycle pulse on decoding an undefined opcode.
- `state_o`  out  4  current state code, for the test bench.

## Operation
- Moore FSM: every output is a function of the state register only.
- Any strobe not listed for a state is 0; `bus_sel` is 00 unless listed.
- Opcodes:
  - 0x0 NOP.
  - 0x1 ADD addr: AC += M[addr].
  - 0x2 STAC addr: M[addr] = AC.
  - 0x3 INAC.
  - 0x4 JUMP addr.
  - 0x5 JMPZ addr.
  - HALT_OPC.
  - All other opcodes are illegal and execute as NOP.
- States, with outputs and then transitions:
  - FETCH1: `bus_sel`=11, `AR_Load`. Next: FETCH2.
  - FETCH2: `bus_sel`=10, `IR_Load`, `PC_Inc`. Next: DECODE.
  - DECODE: no strobes. Next by opcode:
    - NOP or illegal: FETCH1. Illegal also pulses `illegal_op` on the next cycle.
    - ADD: ADD1. STAC: ST1. INAC: INC1. JUMP: JMP1.
    - JMPZ: JMP1 if `ac_zero`=1, otherwise JZSKIP.
    - HALT_OPC: HALT.
  - ADD1: `bus_sel`=11, `AR_Load`. Next: ADD2.
  - ADD2: `bus_sel`=10, `AR_Load`, `PC_Inc`. Next: ADD3.
  - ADD3: `bus_sel`=10, `DR_Load`. Next: ADD4.
  - ADD4: `AC_Load`. Next: FETCH1.
  - ST1: `bus_sel`=11, `AR_Load`. Next: ST2.
  - ST2: `bus_sel`=10, `AR_Load`, `PC_Inc`. Next: ST3.
  - ST3: `bus_sel`=01, `mem_we`. Next: FETCH1.
  - INC1: `AC_Inc`. Next: FETCH1.
  - JMP1: `bus_sel`=11, `AR_Load`. Next: JMP2.
  - JMP2: `bus_sel`=10, `PC_Load`. Next: FETCH1.
  - JZSKIP: `PC_Inc`, which steps over the operand byte. Next: FETCH1.
  - HALT: `halted`=1, no strobes. Stays in HALT until reset.
- `ac_zero` is sampled only on the DECODE clock edge.
- At most one load or increment targets any single register per state. `PC_Load` and `PC_Inc` are never both asserted.

## Timing
- Reset: asynchronous entry to FETCH1 with every strobe, `mem_we`, `halted` and `illegal_op` at 0, `bus_sel`=00, `alu_sel`=000.
  - Reset mid-instruction abandons it; no partial store is issued after `rst` falls.
  - The first FETCH1 strobe is visible on the first rising edge after `rst` rises.
- Memory read is combinational: data for AR is valid in the cycle after `AR_Load`.
- Cycles per instruction, FETCH1 through return to FETCH1:
  - NOP / illegal: 3.
  - INAC: 4.
  - JMPZ not taken: 4.
  - JUMP: 5.
  - JMPZ taken: 5.
  - STAC: 6.
  - ADD: 7.
- `illegal_op` is high exactly during the FETCH1 cycle that follows the illegal DECODE.
- PC arithmetic wraps modulo 256 in the data path; the sequencer applies no bounds check.

## Configuration
- `CU_JMPZ_EN` defined: opcode 0x5 is JMPZ, as specified above.
- `CU_JMPZ_EN` undefined: the JZSKIP state is removed and 0x5 is illegal. It runs as a 3-cycle NOP with an `illegal_op` pulse, and the PC does not skip the operand byte.

## Test plan
- Reset then NOP stream: PC starts at 8'h10, advances by 1 every 3 cycles; `state_o` cycles FETCH1→FETCH2→DECODE; no `mem_we`.
- Program 8'h30, 8'h30 (INAC twice) then HALT_OPC<<4: AC = 8'h02, `halted`=1 at cycle 11, PC = 8'h13 and frozen thereafter.
- ADD/STAC:
  - Setup: M[0x80]=8'h05, AC=0.
  - Program: 8'h10 8'h80 (ADD), then 8'h20 8'h81 (STAC).
  - Expected: AC = 8'h05 after 7 cycles; M[0x81] = 8'h05; `mem_we` high for exactly one cycle with `bus_sel`=01.
- JMPZ:
  - AC=0: JMPZ 8'h40 sets PC=8'h40 in 5 cycles.
  - AC=1: same instruction leaves PC = old PC+2 in 4 cycles.
  - Repeat with `CU_JMPZ_EN` undefined: `illegal_op` pulses and PC = old PC+1.
- Opcode 0xA: one-cycle `illegal_op` pulse, 3-cycle NOP.
- Assert `rst`=0 during ST2: outputs clear immediately and asynchronously; no `mem_we` appears; after release, fetch resumes from PC 8'h10.
